md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ir_d  input  32  instruction in D stage; used only for stall detection.
REQ-006 SHALL have port ir_e  input  32  instruction in E stage; used for start, mthi/mtlo and mfhi/mflo.
REQ-007 SHALL have port rs_val  input  32  forwarded rs value of ir_e.
REQ-008 SHALL have port rt_val  input  32  forwarded rt value of ir_e.
REQ-009 SHALL have port hi  output  32  committed HI register.
REQ-010 SHALL have port lo  output  32  committed LO register.
REQ-011 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-012 SHALL have port md_stall  output  1  stall request OR-ed into the pipeline stall.
REQ-013 SHALL have port md_out  output  32  E-stage result of mfhi/mflo, else 0.

Function
REQ-014 SHALL classify SPECIAL (opcode 0) funct: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13; "md-class" = any of these eight.
REQ-015 SHALL implement states IDLE, MULT, DIV; busy = (state != IDLE).
REQ-016 SHALL assert start when ir_e is mult/multu/div/divu and state is IDLE; start in a non-IDLE state SHALL be ignored (the stall rule prevents it).
REQ-017 SHALL on start latch rs_val/rt_val, compute the result, hold it in pending registers, load cnt with MULT_CYCLES-1 or DIV_CYCLES-1, enter MULT or DIV.
REQ-018 SHALL decrement cnt each cycle in MULT/DIV; on the edge where cnt==0 SHALL commit pending to hi/lo and return to IDLE, so busy is high exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-019 mult/multu SHALL produce the 64-bit signed/unsigned product, hi = [63:32], lo = [31:0].
REQ-020 div/divu SHALL produce lo = quotient (truncated toward zero), hi = remainder (sign of dividend); signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 Division by zero SHALL still take DIV_CYCLES and SHALL leave hi/lo unchanged at commit.
REQ-022 mthi/mtlo in E while IDLE SHALL write rs_val to hi/lo at the next edge; in E while busy SHALL not occur (stalled).
REQ-023 md_out SHALL be hi when ir_e is mfhi, lo when mflo, else 0; combinational.
REQ-024 md_stall SHALL be (busy OR start) AND ir_d is md-class; combinational, no latency.
REQ-025 Non-md instructions SHALL proceed without stall while busy.
REQ-026 The commit edge and a new start SHALL not coincide (the start requires IDLE); the cycle after commit SHALL accept a start.

Reset
REQ-027 On reset high at a clock edge: state=IDLE, cnt=0, hi=0, lo=0, pending=0, busy=0, md_stall=0 unless combinationally driven by start; any in-flight operation SHALL be discarded, not committed.

Structure
REQ-028 Funct codes, state encodings and default cycle counts SHALL live in the shared header/package of the CPU.
REQ-029 A sub-module md_decode (ir -> is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, is_md) SHALL be instantiated for ir_d and ir_e.

Verification
REQ-030 mult rs=0xFFFFFFFF, rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 div rs=-7, rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7, rt=0 -> hi/lo unchanged after 10 cycles.
REQ-032 mult in E with mflo in D -> md_stall high from start cycle through the last busy cycle (6 cycles), mflo in E next then gives md_out = new lo.
REQ-033 mult in E followed by addu in D -> md_stall stays 0, busy 5 cycles.
REQ-034 mthi rs=0x12345678 in E while IDLE -> hi=0x12345678 next cycle; mfhi following -> md_out=0x12345678.
REQ-035 div started, reset asserted on busy cycle 3 -> next cycle state IDLE, hi=lo=0, busy=0, no later commit.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared HI/LO multiply-divide definitions: funct codes, FSM encoding, default latencies.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package md_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_decode.sv
// Decodes one instruction word into the HI/LO unit's instruction classes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ir (instruction word) -> one flag per md instruction, plus is_md = any of them.
module md_decode
    import md_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_mult,
    output logic        is_multu,
    output logic        is_div,
    output logic        is_divu,
    output logic        is_mfhi,
    output logic        is_mflo,
    output logic        is_mthi,
    output logic        is_mtlo,
    output logic        is_md
);

    logic       w_special;
    logic [5:0] w_funct;
    logic       w_unused_ir;

    assign w_special   = (ir[31:26] == OP_SPECIAL);
    assign w_funct     = ir[5:0];
    // Register fields are irrelevant to classification.
    assign w_unused_ir = ^ir[25:6];

    assign is_mult  = w_special && (w_funct == FN_MULT);
    assign is_multu = w_special && (w_funct == FN_MULTU);
    assign is_div   = w_special && (w_funct == FN_DIV);
    assign is_divu  = w_special && (w_funct == FN_DIVU);
    assign is_mfhi  = w_special && (w_funct == FN_MFHI);
    assign is_mflo  = w_special && (w_funct == FN_MFLO);
    assign is_mthi  = w_special && (w_funct == FN_MTHI);
    assign is_mtlo  = w_special && (w_funct == FN_MTLO);

    assign is_md = is_mult | is_multu | is_div | is_divu |
                   is_mfhi | is_mflo | is_mthi | is_mtlo;

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply-divide controller: fixed-latency mult/div with pending result, mthi/mtlo, mfhi/mflo.
// Latency: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES; mthi/mtlo 1 cycle; md_out combinational.
// Backpressure: md_stall holds any md-class instruction in D while busy or starting.
// Ports: clk, reset (sync, active-high); ir_d/ir_e instructions in D/E; rs_val/rt_val E operands;
//        hi/lo committed registers; busy; md_stall; md_out (mfhi/mflo result in E, else 0).
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_d,
    input  logic [31:0] ir_e,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out
);

    // ---------------- decode ----------------
    logic w_d_mult, w_d_multu, w_d_div, w_d_divu;
    logic w_d_mfhi, w_d_mflo, w_d_mthi, w_d_mtlo, w_d_md;
    logic w_e_mult, w_e_multu, w_e_div, w_e_divu;
    logic w_e_mfhi, w_e_mflo, w_e_mthi, w_e_mtlo, w_e_md;
    logic w_unused_dec;

    md_decode u_dec_d (
        .ir       (ir_d),
        .is_mult  (w_d_mult),
        .is_multu (w_d_multu),
        .is_div   (w_d_div),
        .is_divu  (w_d_divu),
        .is_mfhi  (w_d_mfhi),
        .is_mflo  (w_d_mflo),
        .is_mthi  (w_d_mthi),
        .is_mtlo  (w_d_mtlo),
        .is_md    (w_d_md)
    );

    md_decode u_dec_e (
        .ir       (ir_e),
        .is_mult  (w_e_mult),
        .is_multu (w_e_multu),
        .is_div   (w_e_div),
        .is_divu  (w_e_divu),
        .is_mfhi  (w_e_mfhi),
        .is_mflo  (w_e_mflo),
        .is_mthi  (w_e_mthi),
        .is_mtlo  (w_e_mtlo),
        .is_md    (w_e_md)
    );

    // D stage only needs the aggregate class for stall detection.
    assign w_unused_dec = ^{w_d_mult, w_d_multu, w_d_div, w_d_divu,
                            w_d_mfhi, w_d_mflo, w_d_mthi, w_d_mtlo, w_e_md};

    // ---------------- state ----------------
    md_state_e   r_state, w_state_nxt;
    logic [31:0] r_cnt,   w_cnt_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;
    logic [31:0] r_p_hi,  w_p_hi_nxt;
    logic [31:0] r_p_lo,  w_p_lo_nxt;
    logic        r_p_we,  w_p_we_nxt;

    logic w_is_mul, w_is_dvd, w_start;

    assign w_is_mul = w_e_mult | w_e_multu;
    assign w_is_dvd = w_e_div  | w_e_divu;
    assign w_start  = (w_is_mul | w_is_dvd) && (r_state == ST_IDLE);

    // ---------------- datapath ----------------
    // Signed product = low 64 bits of the product of sign-extended operands.
    logic [63:0] w_op_a, w_op_b, w_prod;
    assign w_op_a = w_e_mult ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    assign w_op_b = w_e_mult ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    assign w_prod = w_op_a * w_op_b;

    // Divisor is forced to 1 on divide-by-zero so the arithmetic stays defined;
    // the result is discarded at commit anyway.
    logic        w_dz, w_ovf;
    logic [31:0] w_dvs, w_q, w_r;
    assign w_dz  = (rt_val == 32'd0);
    assign w_dvs = w_dz ? 32'd1 : rt_val;
    // Only overflowing signed case: most-negative / -1.
    assign w_ovf = w_e_div && (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    always_comb begin
        w_q = 32'd0;
        w_r = 32'd0;
        if (w_ovf) begin
            w_q = 32'h8000_0000;
            w_r = 32'd0;
        end else if (w_e_div) begin
            w_q = $signed(rs_val) / $signed(w_dvs);
            w_r = $signed(rs_val) % $signed(w_dvs);
        end else begin
            w_q = rs_val / w_dvs;
            w_r = rs_val % w_dvs;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_p_we_nxt  = r_p_we;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_is_mul) begin
                        w_p_hi_nxt  = w_prod[63:32];
                        w_p_lo_nxt  = w_prod[31:0];
                        w_p_we_nxt  = 1'b1;
                        w_cnt_nxt   = 32'(MULT_CYCLES - 1);
                        w_state_nxt = ST_MULT;
                    end else begin
                        w_p_hi_nxt  = w_r;
                        w_p_lo_nxt  = w_q;
                        w_p_we_nxt  = !w_dz;
                        w_cnt_nxt   = 32'(DIV_CYCLES - 1);
                        w_state_nxt = ST_DIV;
                    end
                end else if (w_e_mthi) begin
                    w_hi_nxt = rs_val;
                end else if (w_e_mtlo) begin
                    w_lo_nxt = rs_val;
                end
            end
            ST_MULT, ST_DIV: begin
                if (r_cnt == 32'd0) begin
                    if (r_p_we) begin
                        w_hi_nxt = r_p_hi;
                        w_lo_nxt = r_p_lo;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_p_we  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_p_we  <= w_p_we_nxt;
        end
    end

    // ---------------- outputs ----------------
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != ST_IDLE);
    assign md_stall = (busy | w_start) & w_d_md;
    assign md_out   = w_e_mfhi ? r_hi : (w_e_mflo ? r_lo : 32'd0);

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_d, ir_e, rs_val, rt_val;
    logic [31:0] hi, lo, md_out;
    logic        busy, md_stall;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .ir_d     (ir_d),
        .ir_e     (ir_e),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_stall_seen = 0;
    int n_busy_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwe;
    int          m_left;   // busy cycles remaining

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 5'd3, 5'd4, 5'd0, 5'd0, fn};
    endfunction

    function automatic bit is_special(input logic [31:0] ir, input logic [5:0] fn);
        return (ir[31:26] == 6'd0) && (ir[5:0] == fn);
    endfunction

    function automatic bit is_muldiv(input logic [31:0] ir);
        return is_special(ir, 6'h18) || is_special(ir, 6'h19) ||
               is_special(ir, 6'h1A) || is_special(ir, 6'h1B);
    endfunction

    function automatic bit is_mdc(input logic [31:0] ir);
        return is_muldiv(ir) || is_special(ir, 6'h10) || is_special(ir, 6'h11) ||
               is_special(ir, 6'h12) || is_special(ir, 6'h13);
    endfunction

    task automatic model_start(input logic [31:0] e, input logic [31:0] rs, input logic [31:0] rt);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(rs);
        sb = $signed(rt);
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        m_pwe = 1'b1;
        if (is_special(e, 6'h18)) begin
            sp = sa * sb;
            m_phi = sp[63:32]; m_plo = sp[31:0];
            m_left = MC;
        end else if (is_special(e, 6'h19)) begin
            up = ua * ub;
            m_phi = up[63:32]; m_plo = up[31:0];
            m_left = MC;
        end else begin
            m_left = DC;
            if (rt == 32'd0) begin
                m_pwe = 1'b0;
            end else if (is_special(e, 6'h1A)) begin
                sq = sa / sb; sr = sa % sb;
                m_plo = sq[31:0]; m_phi = sr[31:0];
            end else begin
                up = ua / ub; m_plo = up[31:0];
                up = ua % ub; m_phi = up[31:0];
            end
        end
    endtask

    // One pipeline cycle: drive, check combinational and registered outputs, clock, update model.
    task automatic step(input logic [31:0] d, input logic [31:0] e,
                        input logic [31:0] rs, input logic [31:0] rt, input logic rst);
        bit          e_busy, e_start, e_stall;
        logic [31:0] e_out;
        ir_d = d; ir_e = e; rs_val = rs; rt_val = rt; reset = rst;
        e_busy  = (m_left != 0);
        e_start = is_muldiv(e) && !e_busy;
        e_stall = (e_busy || e_start) && is_mdc(d);
        e_out   = is_special(e, 6'h10) ? m_hi : (is_special(e, 6'h12) ? m_lo : 32'd0);
        @(negedge clk);
        chk("busy",     {31'd0, busy},     {31'd0, e_busy});
        chk("md_stall", {31'd0, md_stall}, {31'd0, e_stall});
        chk("md_out",   md_out, e_out);
        chk("hi",       hi, m_hi);
        chk("lo",       lo, m_lo);
        if (md_stall) n_stall_seen++;
        if (busy)     n_busy_seen++;
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwe) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (e_start) begin
            model_start(e, rs, rt);
        end else if (is_special(e, 6'h11)) begin
            m_hi = rs;
        end else if (is_special(e, 6'h13)) begin
            m_lo = rs;
        end
        #1;
    endtask

    // ---------------- random stimulus helpers ----------------
    function automatic logic [31:0] rand_ir(input bit allow_mt);
        logic [31:0] ir;
        int unsigned k;
        ir = $urandom;
        k  = $urandom_range(0, 9);
        if (k <= 7) begin
            ir[31:26] = 6'd0;
            case (k)
                0: ir[5:0] = 6'h18;
                1: ir[5:0] = 6'h19;
                2: ir[5:0] = 6'h1A;
                3: ir[5:0] = 6'h1B;
                4: ir[5:0] = 6'h10;
                5: ir[5:0] = 6'h12;
                6: ir[5:0] = 6'h11;
                default: ir[5:0] = 6'h13;
            endcase
            if (!allow_mt && (k == 6 || k == 7)) ir[5:0] = 6'h21;
        end else if (k == 8) begin
            ir[31:26] = 6'($urandom_range(1, 63));
        end else begin
            ir[31:26] = 6'd0;
            if (is_mdc(ir)) ir[5:0] = 6'h21;
        end
        return ir;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'd7;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] NOP, ADDU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI;

    initial begin
        NOP  = rtype(6'h21); ADDU = rtype(6'h21);
        MULT = rtype(6'h18); MULTU = rtype(6'h19);
        DIV  = rtype(6'h1A); DIVU  = rtype(6'h1B);
        MFHI = rtype(6'h10); MFLO  = rtype(6'h12); MTHI = rtype(6'h11);
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;
        ir_d = NOP; ir_e = NOP; rs_val = 0; rt_val = 0; reset = 1'b1;

        step(NOP, NOP, 0, 0, 1'b1);
        step(NOP, NOP, 0, 0, 1'b1);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // signed / unsigned multiply of -1 by 2
        n_busy_seen = 0;
        step(NOP, MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        repeat (6) step(NOP, NOP, 0, 0, 1'b0);
        chk("mult_busy_cycles", n_busy_seen, MC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        step(NOP, MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        repeat (5) step(NOP, NOP, 0, 0, 1'b0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // signed divide -7/2, then divide by zero leaves HI/LO alone
        n_busy_seen = 0;
        step(NOP, DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (11) step(NOP, NOP, 0, 0, 1'b0);
        chk("div_busy_cycles", n_busy_seen, DC);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        step(NOP, DIVU, 32'd7, 32'd0, 1'b0);
        repeat (10) step(NOP, NOP, 0, 0, 1'b0);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        chk("divz_lo", lo, 32'hFFFF_FFFD);

        // overflow corner
        step(NOP, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        repeat (10) step(NOP, NOP, 0, 0, 1'b0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        // mflo waiting in D behind a mult
        n_stall_seen = 0;
        step(MFLO, MULT, 32'd3, 32'd4, 1'b0);
        repeat (5) step(MFLO, NOP, 0, 0, 1'b0);
        chk("mflo_stall_cycles", n_stall_seen, 6);
        ir_d = NOP; ir_e = MFLO; #1;
        chk("mflo_after_mult", md_out, 32'd12);
        step(NOP, MFLO, 0, 0, 1'b0);

        // non-md instruction behind a mult never stalls
        n_stall_seen = 0;
        step(ADDU, MULT, 32'd5, 32'd6, 1'b0);
        repeat (5) step(ADDU, NOP, 0, 0, 1'b0);
        chk("addu_no_stall", n_stall_seen, 0);

        // mthi then mfhi
        step(NOP, MTHI, 32'h1234_5678, 0, 1'b0);
        chk("mthi_hi", hi, 32'h1234_5678);
        ir_d = NOP; ir_e = MFHI; #1;
        chk("mfhi_out", md_out, 32'h1234_5678);
        step(NOP, MFHI, 0, 0, 1'b0);

        // reset in the middle of a divide discards it
        step(NOP, DIV, 32'd100, 32'd3, 1'b0);
        step(NOP, NOP, 0, 0, 1'b0);
        step(NOP, NOP, 0, 0, 1'b0);
        step(NOP, NOP, 0, 0, 1'b1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (12) step(NOP, NOP, 0, 0, 1'b0);
        chk("rst_no_commit_lo", lo, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(rand_ir(1'b1), rand_ir(m_left == 0), rand_val(), rand_val(),
                 ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
